// File: rtl/seq_pkg.sv
// Shared definitions for the multi-cycle RV32I sequencer:
// state encodings, opcode constants, instruction class enum and error codes.
package seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_BAD    = 3'd7
  } state_t;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    CLS_NONE    = 3'd0,
    CLS_ALU     = 3'd1,
    CLS_LOAD    = 3'd2,
    CLS_STORE   = 3'd3,
    CLS_BRANCH  = 3'd4,
    CLS_SYSTEM  = 3'd5,
    CLS_ILLEGAL = 3'd6
  } cls_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL  = 2'd1;
  localparam logic [1:0] ERR_FETCH_TO = 2'd2;
  localparam logic [1:0] ERR_MEM_TO   = 2'd3;

  function automatic cls_t classify(input logic [6:0] opc);
    cls_t c;
    case (opc)
      OPC_RTYPE, OPC_ITYPE: c = CLS_ALU;
      OPC_LOAD:             c = CLS_LOAD;
      OPC_STORE:            c = CLS_STORE;
      OPC_BRANCH:           c = CLS_BRANCH;
      OPC_SYSTEM:           c = CLS_SYSTEM;
      default:              c = CLS_ILLEGAL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Wait-cycle counter for the sequencer's handshake states.
// Ports:
//   clk      - clock
//   rst      - asynchronous active-low reset
//   clr      - synchronous clear (takes priority over inc)
//   inc      - count one waiting cycle
//   at_limit - this is the TIMEOUT-th waiting cycle; a missing ready now faults
module seq_wait_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic at_limit
);

  localparam int W = 10;

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (inc)  cnt <= cnt + 10'd1;
  end

  // cnt holds the number of cycles already waited, so the current cycle is
  // the last allowed one when cnt == TIMEOUT-1.
  assign at_limit = (cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_seq_ctrl.sv
// Multi-cycle sequencer for the single-issue RV32I datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the
// datapath strobes; halts on illegal opcodes, SYSTEM or handshake timeouts.
// Optional build macro: SEQ_PERF_CNT_EN adds retired_cnt and stall_cnt.
// Ports:
//   clk, rst (async active-low), start, stop, opcode[6:0],
//   ifetch_ready, mem_ready                          - inputs
//   ifetch_req, ir_write, pc_write, reg_write_en,
//   mem_read_en, mem_write_en, retire, busy, halted,
//   err_code[1:0], state_dbg[2:0]                    - outputs
//   retired_cnt, stall_cnt [CNT_W-1:0]               - outputs, SEQ_PERF_CNT_EN only
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | instruction fetch request, waiting on ifetch_ready
// DECODE | classify opcode, latch class
// EXEC   | branch retires here; others proceed
// MEM    | data access strobe held until mem_ready
// WB     | register write and PC update
// HALT   | sticky stop, exits only via reset
module multicycle_seq_ctrl
  import seq_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [6:0]       opcode,
  input  logic             ifetch_ready,
  input  logic             mem_ready,
  output logic             ifetch_req,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write_en,
  output logic             mem_read_en,
  output logic             mem_write_en,
  output logic             retire,
  output logic             busy,
  output logic             halted,
  output logic [1:0]       err_code,
  output logic [2:0]       state_dbg
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  if (TIMEOUT < 1 || TIMEOUT > 1023 || CNT_W < 1) begin : g_param_check
    $error("multicycle_seq_ctrl: TIMEOUT must be 1..1023 and CNT_W >= 1");
  end

  state_t     state, state_nxt, ret_state;
  cls_t       cls_q, cls_nxt, dec_cls;
  logic [1:0] err_q, err_nxt;
  logic       wait_inc, at_limit;

  seq_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (state_nxt != state),
    .inc      (wait_inc),
    .at_limit (at_limit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cls_q <= CLS_NONE;
      err_q <= ERR_NONE;
    end else begin
      state <= state_nxt;
      cls_q <= cls_nxt;
      err_q <= err_nxt;
    end
  end

  assign dec_cls   = classify(opcode);
  assign ret_state = stop ? ST_IDLE : ST_FETCH;

  always_comb begin
    state_nxt    = state;
    cls_nxt      = cls_q;
    err_nxt      = err_q;
    ifetch_req   = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    reg_write_en = 1'b0;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    wait_inc     = 1'b0;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_FETCH;
      ST_FETCH: begin
        ifetch_req = 1'b1;
        if (ifetch_ready) begin
          ir_write  = 1'b1;
          state_nxt = ST_DECODE;
        end else begin
          wait_inc = 1'b1;
          if (at_limit) begin
            state_nxt = ST_HALT;
            err_nxt   = ERR_FETCH_TO;
          end
        end
      end
      ST_DECODE: begin
        cls_nxt = dec_cls;
        case (dec_cls)
          CLS_ILLEGAL: begin
            state_nxt = ST_HALT;
            err_nxt   = ERR_ILLEGAL;
          end
          CLS_SYSTEM: state_nxt = ST_HALT;
          default:    state_nxt = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        case (cls_q)
          CLS_BRANCH: begin
            pc_write  = 1'b1;
            state_nxt = ret_state;
          end
          CLS_LOAD, CLS_STORE: state_nxt = ST_MEM;
          default:             state_nxt = ST_WB;
        endcase
      end
      ST_MEM: begin
        mem_read_en  = (cls_q == CLS_LOAD);
        mem_write_en = (cls_q == CLS_STORE);
        if (mem_ready) begin
          if (cls_q == CLS_LOAD) begin
            state_nxt = ST_WB;
          end else begin
            pc_write  = 1'b1;
            state_nxt = ret_state;
          end
        end else begin
          wait_inc = 1'b1;
          if (at_limit) begin
            state_nxt = ST_HALT;
            err_nxt   = ERR_MEM_TO;
          end
        end
      end
      ST_WB: begin
        reg_write_en = 1'b1;
        pc_write     = 1'b1;
        state_nxt    = ret_state;
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign retire    = pc_write;
  assign busy      = (state != ST_IDLE) && (state != ST_HALT);
  assign halted    = (state == ST_HALT);
  assign err_code  = err_q;
  assign state_dbg = state;

`ifdef SEQ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retired_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (retire) retired_cnt <= retired_cnt + 1'b1;
      if (wait_inc && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_seq_ctrl.sv
module tb_multicycle_seq_ctrl;

  localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3,
                         MEM = 3'd4, WB = 3'd5, HALT = 3'd6;
  localparam logic [6:0] OP_ADDI = 7'b0010011, OP_ADD = 7'b0110011, OP_LW = 7'b0000011,
                         OP_SW = 7'b0100011, OP_BEQ = 7'b1100011, OP_ECALL = 7'b1110011,
                         OP_BAD = 7'b1111111;
  // strobe field order: ifetch_req, ir_write, pc_write, reg_write_en, mem_read_en, mem_write_en
  localparam logic [5:0] S_0 = 6'b000000, S_IF = 6'b100000, S_IR = 6'b010000, S_PC = 6'b001000,
                         S_RW = 6'b000100, S_MR = 6'b000010, S_MW = 6'b000001;

  typedef struct packed {
    logic       start;
    logic       stop;
    logic [6:0] opcode;
    logic       ifr;
    logic       mr;
  } stim_t;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, stop = 1'b0;
  logic [6:0] opcode = '0;
  logic ifetch_ready = 1'b0, mem_ready = 1'b0;
  logic ifetch_req, ir_write, pc_write, reg_write_en, mem_read_en, mem_write_en;
  logic retire, busy, halted;
  logic [1:0] err_code;
  logic [2:0] state_dbg;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] retired_cnt, stall_cnt;
`endif

  int vectors = 0;
  int errors  = 0;
  stim_t       stim_q[$];
  logic [13:0] exp_q[$];

  multicycle_seq_ctrl #(.TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .opcode(opcode),
    .ifetch_ready(ifetch_ready), .mem_ready(mem_ready),
    .ifetch_req(ifetch_req), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write_en(reg_write_en), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .retire(retire), .busy(busy), .halted(halted), .err_code(err_code), .state_dbg(state_dbg)
`ifdef SEQ_PERF_CNT_EN
    , .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] obs();
    return {state_dbg, err_code, ifetch_req, ir_write, pc_write, reg_write_en,
            mem_read_en, mem_write_en, retire, busy, halted};
  endfunction

  // Expected output word: retire mirrors pc_write, busy/halted follow the state.
  task automatic push(input logic st_i, input logic sp_i, input logic [6:0] op_i,
                      input logic ifr_i, input logic mr_i,
                      input logic [2:0] st, input logic [1:0] err, input logic [5:0] sb);
    stim_t s;
    s = '{start: st_i, stop: sp_i, opcode: op_i, ifr: ifr_i, mr: mr_i};
    stim_q.push_back(s);
    exp_q.push_back({st, err, sb, sb[3], (st != IDLE) && (st != HALT), st == HALT});
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0; start = 0; stop = 0; ifetch_ready = 0; mem_ready = 0; opcode = '0;
    #1;
    vectors++;
    if (obs() !== 14'd0) begin
      errors++; $display("FAIL reset_asserted got %h want %h", obs(), 14'd0);
    end
`ifdef SEQ_PERF_CNT_EN
    vectors++;
    if (retired_cnt !== 0 || stall_cnt !== 0) begin
      errors++; $display("FAIL reset_counters got %0d/%0d want 0/0", retired_cnt, stall_cnt);
    end
`endif
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if (obs() !== 14'd0) begin
      errors++; $display("FAIL reset_released got %h want %h", obs(), 14'd0);
    end
  endtask

  task automatic test_addi();
    push(1, 1, OP_ADDI, 0, 1, IDLE,   0, S_0);
    push(0, 1, OP_ADDI, 1, 1, FETCH,  0, S_IF | S_IR);
    push(0, 1, OP_ADDI, 1, 1, DECODE, 0, S_0);        // stray ifetch_ready ignored
    push(0, 1, OP_ADDI, 0, 1, EXEC,   0, S_0);        // stray mem_ready ignored
    push(0, 1, OP_ADDI, 0, 1, WB,     0, S_PC | S_RW);
    push(0, 0, OP_ADDI, 0, 0, IDLE,   0, S_0);
    for (int i = 0; stim_q.size() > 0; i++) begin
      stim_t s; logic [13:0] e;
      s = stim_q.pop_front(); e = exp_q.pop_front();
      @(negedge clk);
      start = s.start; stop = s.stop; opcode = s.opcode; ifetch_ready = s.ifr; mem_ready = s.mr;
      #1;
      vectors++;
      if (obs() !== e) begin
        errors++; $display("FAIL addi cyc%0d got %h want %h", i, obs(), e);
      end
    end
  endtask

  task automatic test_load_wait();
    push(1, 0, OP_LW, 0, 0, IDLE,   0, S_0);
    push(0, 0, OP_LW, 1, 0, FETCH,  0, S_IF | S_IR);
    push(0, 0, OP_LW, 0, 0, DECODE, 0, S_0);
    push(0, 0, OP_LW, 0, 0, EXEC,   0, S_0);
    push(0, 0, OP_LW, 0, 0, MEM,    0, S_MR);
    push(0, 0, OP_LW, 0, 0, MEM,    0, S_MR);
    push(0, 0, OP_LW, 0, 0, MEM,    0, S_MR);
    push(0, 0, OP_LW, 0, 1, MEM,    0, S_MR);         // ready on the limit cycle wins
    push(0, 1, OP_LW, 0, 0, WB,     0, S_PC | S_RW);
    push(0, 0, OP_LW, 0, 0, IDLE,   0, S_0);
    for (int i = 0; stim_q.size() > 0; i++) begin
      stim_t s; logic [13:0] e;
      s = stim_q.pop_front(); e = exp_q.pop_front();
      @(negedge clk);
      start = s.start; stop = s.stop; opcode = s.opcode; ifetch_ready = s.ifr; mem_ready = s.mr;
      #1;
      vectors++;
      if (obs() !== e) begin
        errors++; $display("FAIL load_wait cyc%0d got %h want %h", i, obs(), e);
      end
    end
  endtask

  task automatic test_back_to_back();
    push(1, 0, OP_SW,  0, 0, IDLE,   0, S_0);
    push(0, 0, OP_SW,  1, 0, FETCH,  0, S_IF | S_IR);
    push(0, 1, OP_SW,  0, 0, DECODE, 0, S_0);         // stop outside retire ignored
    push(0, 1, OP_SW,  0, 0, EXEC,   0, S_0);
    push(0, 0, OP_SW,  0, 1, MEM,    0, S_MW | S_PC);
    push(0, 0, OP_BEQ, 1, 0, FETCH,  0, S_IF | S_IR);
    push(0, 0, OP_BEQ, 0, 0, DECODE, 0, S_0);
    push(1, 1, OP_BEQ, 0, 0, EXEC,   0, S_PC);        // start while busy ignored
    push(0, 0, OP_BEQ, 0, 0, IDLE,   0, S_0);
    for (int i = 0; stim_q.size() > 0; i++) begin
      stim_t s; logic [13:0] e;
      s = stim_q.pop_front(); e = exp_q.pop_front();
      @(negedge clk);
      start = s.start; stop = s.stop; opcode = s.opcode; ifetch_ready = s.ifr; mem_ready = s.mr;
      #1;
      vectors++;
      if (obs() !== e) begin
        errors++; $display("FAIL back_to_back cyc%0d got %h want %h", i, obs(), e);
      end
    end
  endtask

  task automatic test_fetch_ready_limit();
    push(1, 1, OP_ADD, 0, 0, IDLE,   0, S_0);
    push(0, 1, OP_ADD, 0, 0, FETCH,  0, S_IF);
    push(0, 1, OP_ADD, 0, 0, FETCH,  0, S_IF);
    push(0, 1, OP_ADD, 0, 0, FETCH,  0, S_IF);
    push(0, 1, OP_ADD, 1, 0, FETCH,  0, S_IF | S_IR);
    push(0, 1, OP_ADD, 0, 0, DECODE, 0, S_0);
    push(0, 1, OP_ADD, 0, 0, EXEC,   0, S_0);
    push(0, 1, OP_ADD, 0, 0, WB,     0, S_PC | S_RW);
    push(0, 0, OP_ADD, 0, 0, IDLE,   0, S_0);
    for (int i = 0; stim_q.size() > 0; i++) begin
      stim_t s; logic [13:0] e;
      s = stim_q.pop_front(); e = exp_q.pop_front();
      @(negedge clk);
      start = s.start; stop = s.stop; opcode = s.opcode; ifetch_ready = s.ifr; mem_ready = s.mr;
      #1;
      vectors++;
      if (obs() !== e) begin
        errors++; $display("FAIL fetch_ready_limit cyc%0d got %h want %h", i, obs(), e);
      end
    end
  endtask

  task automatic test_reset_mid_mem();
    push(1, 0, OP_SW, 0, 0, IDLE,   0, S_0);
    push(0, 0, OP_SW, 1, 0, FETCH,  0, S_IF | S_IR);
    push(0, 0, OP_SW, 0, 0, DECODE, 0, S_0);
    push(0, 0, OP_SW, 0, 0, EXEC,   0, S_0);
    push(0, 0, OP_SW, 0, 0, MEM,    0, S_MW);
    for (int i = 0; stim_q.size() > 0; i++) begin
      stim_t s; logic [13:0] e;
      s = stim_q.pop_front(); e = exp_q.pop_front();
      @(negedge clk);
      start = s.start; stop = s.stop; opcode = s.opcode; ifetch_ready = s.ifr; mem_ready = s.mr;
      #1;
      vectors++;
      if (obs() !== e) begin
        errors++; $display("FAIL reset_mid_mem cyc%0d got %h want %h", i, obs(), e);
      end
    end
`ifdef SEQ_PERF_CNT_EN
    // Since the last reset: ADDI, LW, SW, BEQ, ADD retired (5); LW waited 3
    // and the fetch-limit run waited 3 cycles (6). The current MEM cycle is not yet clocked.
    vectors++;
    if (retired_cnt !== 32'd5 || stall_cnt !== 32'd6) begin
      errors++; $display("FAIL perf_counts got %0d/%0d want 5/6", retired_cnt, stall_cnt);
    end
`endif
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (mem_write_en !== 1'b0 || state_dbg !== 3'd0 || obs() !== 14'd0) begin
      errors++; $display("FAIL async_reset_mem got mwe=%b st=%0d all=%h want 0/0/0", mem_write_en, state_dbg, obs());
    end
`ifdef SEQ_PERF_CNT_EN
    vectors++;
    if (retired_cnt !== 32'd0) begin
      errors++; $display("FAIL async_reset_retired got %0d want 0", retired_cnt);
    end
`endif
    @(negedge clk);
    rst = 1'b1; start = 0; mem_ready = 0; ifetch_ready = 0;
  endtask

  task automatic test_illegal();
    push(1, 0, OP_BAD, 0, 0, IDLE,   0, S_0);
    push(0, 0, OP_BAD, 1, 0, FETCH,  0, S_IF | S_IR);
    push(0, 0, OP_BAD, 0, 0, DECODE, 0, S_0);
    push(1, 0, OP_BAD, 1, 1, HALT,   1, S_0);         // start and readies ignored
    push(1, 0, OP_ADDI, 1, 1, HALT,  1, S_0);
    push(0, 0, OP_ADDI, 0, 0, HALT,  1, S_0);
    for (int i = 0; stim_q.size() > 0; i++) begin
      stim_t s; logic [13:0] e;
      s = stim_q.pop_front(); e = exp_q.pop_front();
      @(negedge clk);
      start = s.start; stop = s.stop; opcode = s.opcode; ifetch_ready = s.ifr; mem_ready = s.mr;
      #1;
      vectors++;
      if (obs() !== e) begin
        errors++; $display("FAIL illegal cyc%0d got %h want %h", i, obs(), e);
      end
    end
  endtask

  task automatic test_fetch_timeout();
    push(1, 0, OP_ADDI, 0, 0, IDLE,  0, S_0);
    push(0, 0, OP_ADDI, 0, 0, FETCH, 0, S_IF);
    push(0, 0, OP_ADDI, 0, 0, FETCH, 0, S_IF);
    push(0, 0, OP_ADDI, 0, 0, FETCH, 0, S_IF);
    push(0, 0, OP_ADDI, 0, 0, FETCH, 0, S_IF);
    push(0, 0, OP_ADDI, 1, 0, HALT,  2, S_0);
    push(1, 0, OP_ADDI, 0, 0, HALT,  2, S_0);
    for (int i = 0; stim_q.size() > 0; i++) begin
      stim_t s; logic [13:0] e;
      s = stim_q.pop_front(); e = exp_q.pop_front();
      @(negedge clk);
      start = s.start; stop = s.stop; opcode = s.opcode; ifetch_ready = s.ifr; mem_ready = s.mr;
      #1;
      vectors++;
      if (obs() !== e) begin
        errors++; $display("FAIL fetch_timeout cyc%0d got %h want %h", i, obs(), e);
      end
    end
  endtask

  task automatic test_system();
    push(1, 0, OP_ECALL, 0, 0, IDLE,   0, S_0);
    push(0, 0, OP_ECALL, 1, 0, FETCH,  0, S_IF | S_IR);
    push(0, 0, OP_ECALL, 0, 0, DECODE, 0, S_0);
    push(0, 0, OP_ECALL, 0, 0, HALT,   0, S_0);
    push(1, 0, OP_ECALL, 0, 0, HALT,   0, S_0);
    for (int i = 0; stim_q.size() > 0; i++) begin
      stim_t s; logic [13:0] e;
      s = stim_q.pop_front(); e = exp_q.pop_front();
      @(negedge clk);
      start = s.start; stop = s.stop; opcode = s.opcode; ifetch_ready = s.ifr; mem_ready = s.mr;
      #1;
      vectors++;
      if (obs() !== e) begin
        errors++; $display("FAIL system cyc%0d got %h want %h", i, obs(), e);
      end
    end
  endtask

  task automatic test_mem_timeout();
    push(1, 0, OP_SW, 0, 0, IDLE,   0, S_0);
    push(0, 0, OP_SW, 1, 0, FETCH,  0, S_IF | S_IR);
    push(0, 0, OP_SW, 0, 0, DECODE, 0, S_0);
    push(0, 0, OP_SW, 0, 0, EXEC,   0, S_0);
    push(0, 0, OP_SW, 0, 0, MEM,    0, S_MW);
    push(0, 0, OP_SW, 0, 0, MEM,    0, S_MW);
    push(0, 0, OP_SW, 0, 0, MEM,    0, S_MW);
    push(0, 0, OP_SW, 0, 0, MEM,    0, S_MW);
    push(0, 0, OP_SW, 0, 1, HALT,   3, S_0);
    push(0, 0, OP_SW, 0, 0, HALT,   3, S_0);
    for (int i = 0; stim_q.size() > 0; i++) begin
      stim_t s; logic [13:0] e;
      s = stim_q.pop_front(); e = exp_q.pop_front();
      @(negedge clk);
      start = s.start; stop = s.stop; opcode = s.opcode; ifetch_ready = s.ifr; mem_ready = s.mr;
      #1;
      vectors++;
      if (obs() !== e) begin
        errors++; $display("FAIL mem_timeout cyc%0d got %h want %h", i, obs(), e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load_wait();
    test_back_to_back();
    test_fetch_ready_limit();
    test_reset_mid_mem();
    test_illegal();
    test_reset();
    test_fetch_timeout();
    test_reset();
    test_system();
    test_reset();
    test_mem_timeout();
    test_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
